// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the asynch_fifo write port. Each requester is granted a
// burst of up to MAX_BURST words, and full is honoured combinationally.
//
// state | meaning
// IDLE  | no owner; the next requester is picked starting from ptr
// BURST | owner writes while req[owner] & ~full; released on last word or drop
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int IW        = $clog2(NREQ)
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  input  logic                 full,
  output logic                 wr_en,
  output logic [DW-1:0]        data_in,
  output logic [IW-1:0]        owner,
  output logic                 busy,
  output logic [15:0]          wr_count
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic [IW-1:0] owner_nxt;
  logic [BW-1:0] burst_cnt;
  logic          found;
  logic          accept;
  logic [DW-1:0] slice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DW +: DW];
  end

  // NREQ is a power of two, so the IW-bit add wraps modulo NREQ
  always_comb begin
    pick  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign busy      = (state == BURST);
  assign accept    = busy & req[owner] & ~full;
  assign wr_en     = accept;
  assign gnt       = accept ? (NREQ'(1) << owner) : '0;
  assign data_in   = busy ? slice[owner] : '0;
  assign owner_nxt = owner + IW'(1);

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            wr_count <= wr_count + 16'd1;
            if (burst_cnt == LAST) begin
              burst_cnt <= '0;
              state     <= IDLE;
              ptr       <= owner_nxt;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end else if (!req[owner] && !full) begin
            // owner withdrew; a drop during full is released once full clears
            state <= IDLE;
            ptr   <= owner_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queued producers, a behavioural
// ownership model and directed plus random scenarios.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic        wr_clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        full;
  logic        wr_en;
  logic [7:0]  data_in;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] wr_count;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAXB)) dut (
    .wr_clk(wr_clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .full(full), .wr_en(wr_en), .data_in(data_in), .owner(owner),
    .busy(busy), .wr_count(wr_count)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk;
  int n_fail;

  // producers: one word queue per requester, presented while enabled
  logic [7:0] qbuf [4][256];
  int         qh [4];
  int         qt [4];
  logic [3:0] en;

  // behavioural model of ownership
  bit  m_busy;
  int  m_owner;
  int  m_ptr;
  int  m_taken;
  int  m_count;
  bit  m_acc;
  logic [31:0] exp_vec;
  logic [7:0]  exp_data;
  logic [7:0]  dut_log [$];
  logic [7:0]  mdl_log [$];
  int          seq [$];
  bit          prev_busy;

  wire [31:0] dut_vec = {gnt, wr_en, data_in, busy, owner, wr_count};

  function automatic int first_req(logic [3:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = en[i] && (qh[i] < qt[i]);
      req_data[i*8 +: 8] = req[i] ? qbuf[i][qh[i]] : 8'($urandom);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_taken = 0; m_count = 0;
    dut_log.delete(); mdl_log.delete(); seq.delete(); prev_busy = 0;
  endtask

  task automatic predict();
    logic [3:0] g;
    m_acc    = m_busy && req[m_owner] && !full;
    g        = m_acc ? (4'b0001 << m_owner) : 4'b0000;
    exp_data = m_busy ? req_data[m_owner*8 +: 8] : 8'h00;
    exp_vec  = {g, m_acc, exp_data, m_busy, 2'(m_owner), 16'(m_count)};
  endtask

  task automatic sample();
    set_inputs();
    #1;
    predict();
    if (wr_en === 1'b1) dut_log.push_back(data_in);
    if (busy === 1'b1 && !prev_busy) seq.push_back(int'(owner));
    prev_busy = (busy === 1'b1);
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (req != 4'b0) begin
        m_owner = first_req(req, m_ptr);
        m_taken = 0;
        m_busy  = 1;
      end
    end else if (m_acc) begin
      m_taken++;
      m_count = (m_count + 1) % 65536;
      mdl_log.push_back(exp_data);
      qh[m_owner]++;
      if (m_taken == MAXB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end else if (!req[m_owner] && !full) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % NREQ;
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    model_edge();
    @(negedge wr_clk);
  endtask

  task automatic load(int i, int n);
    for (int k = 0; k < n; k++) qbuf[i][qt[i] + k] = 8'($urandom);
    qt[i] += n;
  endtask

  task automatic apply_reset();
    rst  = 1'b0;
    en   = 4'b0;
    full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
    set_inputs();
    repeat (2) @(negedge wr_clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; load(i, 4); end
    en = 4'hF;
    set_inputs();
    #1;
    if (dut_vec !== 32'h0) begin
      n_fail++; $display("FAIL reset_t0: dut %h exp 00000000", dut_vec);
    end
    n_chk++;
    repeat (2) @(negedge wr_clk);
    #1;
    if (dut_vec !== 32'h0) begin
      n_fail++; $display("FAIL reset_clocked: dut %h exp 00000000", dut_vec);
    end
    n_chk++;
    apply_reset();
  endtask

  task automatic test_single_burst();
    apply_reset();
    for (int k = 0; k < 6; k++) qbuf[0][k] = 8'(10 + k);
    qt[0] = 6;
    en = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL single c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    #1;
    if (wr_count !== 16'd6) begin
      n_fail++; $display("FAIL single_count: dut %0d exp 6", wr_count);
    end
    n_chk++;
    for (int k = 0; k < 6; k++) begin
      if (k >= dut_log.size() || dut_log[k] !== 8'(10 + k)) begin
        n_fail++;
        $display("FAIL single_word%0d: dut %h exp %h", k,
                 (k < dut_log.size()) ? dut_log[k] : 8'hxx, 8'(10 + k));
      end
      n_chk++;
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NREQ; i++) load(i, 40);
    en = 4'hF;
    for (int c = 0; c < 24; c++) begin
      sample();
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL rr c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    for (int k = 0; k < 5; k++) begin
      if (k >= seq.size() || seq[k] != k % NREQ) begin
        n_fail++;
        $display("FAIL rr_owner%0d: dut %0d exp %0d", k,
                 (k < seq.size()) ? seq[k] : -1, k % NREQ);
      end
      n_chk++;
    end
  endtask

  task automatic test_full_stall();
    int stall_bad;
    stall_bad = 0;
    apply_reset();
    load(1, 5);
    en = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      full = (c >= 3 && c <= 5);
      sample();
      if (full && (wr_en !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1 || owner !== 2'd1))
        stall_bad++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL stall c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    full = 1'b0;
    if (stall_bad != 0) begin
      n_fail++; $display("FAIL stall_hold: bad cycles %0d exp 0", stall_bad);
    end
    n_chk++;
    if (dut_log.size() != 5) begin
      n_fail++; $display("FAIL stall_words: dut %0d words exp 5", dut_log.size());
    end else begin
      for (int k = 0; k < 5; k++)
        if (dut_log[k] !== qbuf[1][k]) begin
          n_fail++; $display("FAIL stall_word%0d: dut %h exp %h", k, dut_log[k], qbuf[1][k]);
        end
    end
    n_chk++;
  endtask

  task automatic test_early_release();
    apply_reset();
    load(2, 2);
    load(3, 10);
    load(0, 10);
    en = 4'b1100;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) en[0] = 1'b1;
      sample();
      if (c == 3) begin
        if (wr_count !== 16'd2) begin
          n_fail++; $display("FAIL early_count: dut %0d exp 2", wr_count);
        end
        n_chk++;
      end
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL early c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    if (seq.size() < 2 || seq[0] != 2 || seq[1] != 3) begin
      n_fail++;
      $display("FAIL early_owners: dut %0d,%0d exp 2,3",
               (seq.size() > 0) ? seq[0] : -1, (seq.size() > 1) ? seq[1] : -1);
    end
    n_chk++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    load(1, 6);
    en = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      sample();
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL rstmid c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    set_inputs();
    #1;
    if (wr_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: wr_en %b busy %b exp 1 1", wr_en, busy);
    end
    n_chk++;
    rst = 1'b0;
    #1;
    if (dut_vec !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async: dut %h exp 00000000", dut_vec);
    end
    n_chk++;
    @(posedge wr_clk);
    @(negedge wr_clk);
    rst = 1'b1;
    model_reset();
    qh[1] = qt[1];
    load(2, 4);
    load(3, 4);
    en = 4'b1100;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL rstmid_after c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    if (seq.size() < 1 || seq[0] != 2) begin
      n_fail++;
      $display("FAIL rstmid_owner: dut %0d exp 2", (seq.size() > 0) ? seq[0] : -1);
    end
    n_chk++;
  endtask

  task automatic test_random();
    int b;
    apply_reset();
    for (int i = 0; i < NREQ; i++) load(i, 200);
    en = 4'hF;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(7) == 0) begin
        b = $urandom_range(3);
        en[b] = ~en[b];
      end
      full = ($urandom_range(3) == 0);
      sample();
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL random c%0d: dut %h exp %h", c, dut_vec, exp_vec);
      end
      n_chk++;
      step();
    end
    full = 1'b0;
    if (dut_log.size() != mdl_log.size()) begin
      n_fail++;
      $display("FAIL random_total: dut %0d words exp %0d", dut_log.size(), mdl_log.size());
    end
    n_chk++;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    full   = 1'b0;
    en     = 4'b0;
    req    = 4'b0;
    req_data = 32'h0;
    model_reset();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of `asynch_fifo` between `NREQ` producers in the write clock domain. Each producer raises a request with its data word. The arbiter grants one owner at a time for a bounded burst of up to `MAX_BURST` words, and drives `wr_en`/`data_in` straight into the FIFO, honouring `full`. It sits between the producer blocks and the FIFO's write side and also keeps a running count of words written.

## Interface
- `NREQ`, 4: number of requesters. Power of two, 2..8.
- `DW`, 8: data width. Matches the FIFO `data_in` width.
- `MAX_BURST`, 4: maximum words accepted per grant, ≥1.
- `IW`, log2(NREQ): owner index width (derived).

- `wr_clk`  in  1  write-domain clock. All state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; bit i means word available on slice i.
- `req_data`  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW].
- `gnt`  out  NREQ  one-hot accept strobe; word on slice i is consumed at this edge.
- `full`  in  1  FIFO full flag.
- `wr_en`  out  1  FIFO write enable.
- `data_in`  out  DW  FIFO write data.
- `owner`  out  IW  current/last owner index.
- `busy`  out  1  high while in BURST.
- `wr_count`  out  16  total words written, wraps modulo 2^16.

## Operation
- FSM states: IDLE and BURST. Registers: `state`, `owner`, `ptr` (next-priority index), `burst_cnt` (0..MAX_BURST-1), `wr_count`.
- **IDLE:**
  - If any `req` bit is set, `owner` latches the first set index searching `ptr`, `ptr+1`, … modulo NREQ.
  - `burst_cnt` is set to 0 and the FSM moves to BURST.
  - `full` is not checked in IDLE.
  - No accept happens in IDLE.
- **BURST:**
  - `accept = req[owner] & ~full` (combinational).
  - `gnt[owner] = accept`; all other `gnt` bits are 0.
  - `wr_en = accept`.
  - `data_in = req_data[owner]` while in BURST, 0 in IDLE.
- **Accept edge:**
  - `burst_cnt` increments and `wr_count` increments.
  - If `burst_cnt == MAX_BURST-1`: go to IDLE and set `ptr` to `owner+1` mod NREQ.
- **Requester drop:** if in BURST, `req[owner]` = 0 and `full` = 0, go to IDLE and set `ptr` to `owner+1`. An owner that drops `req` while `full` is high is also released once `full` clears.
- **Full stall:** while `full` = 1, no accept happens. The FSM stays in BURST, `owner` and `burst_cnt` are held, and ownership is not lost.
- `busy` = (state == BURST). `owner` holds its last value in IDLE.
- **Requester rules:**
  - Hold `req` and `req_data` stable until `gnt` is seen.
  - On a `gnt` edge, the next word may be presented in the following cycle.
  - `req` may be dropped at any time that it is not granted.
- **Reset (`rst` = 0), asynchronous:**
  - state=IDLE, owner=0, ptr=0, burst_cnt=0, wr_count=0.
  - `gnt`, `wr_en` and `busy` fall immediately (combinational from state), and `data_in`=0.
  - Reset mid-burst discards the burst; no partial write is issued.

## Timing
- A request in IDLE is sampled at edge E.
- Cycle E→E+1: BURST, and `gnt`/`wr_en` are high in that same cycle if `full` = 0.
- The FIFO captures the word at edge E+1.
- Arbitration overhead: 1 idle cycle between bursts.
- Steady-state throughput: MAX_BURST words per MAX_BURST+1 cycles.
- `full` is used combinationally, so there is no overflow window. A `full` that rises after edge N blocks the accept of cycle N→N+1.
- **Starvation bound:** a requester holding `req` is granted within (NREQ-1)×(MAX_BURST+1)+1 cycles, excluding `full` stall cycles.

## Test plan
- **Single burst split:** after reset, `req[0]` holds 6 sequential words 10..15, `full`=0 → writes 10,11,12,13 on 4 consecutive cycles, 1 IDLE cycle, then owner 0 regranted for 14,15. `wr_count`=6.
- **Round robin:** all four `req` high continuously → owner sequence 0,1,2,3,0. Each owner gets 4 words; exactly 1 IDLE cycle between bursts.
- **Full stall:** `full` forced high for 3 cycles after owner 1's second word → `wr_en`/`gnt` low for those 3 cycles, owner stays 1, `busy`=1. The third word is written on the first cycle after `full` falls; no word is lost or duplicated.
- **Early release:** `req[2]` drops after 2 accepted words while `req[3]` is high → FSM returns to IDLE, `ptr`=3, owner 3 granted next. `wr_count` increases by 2 for owner 2.
- **Reset mid-burst:** `rst`=0 during owner 1's burst → `wr_en`, `gnt` and `busy` go to 0 without waiting for a clock edge, and `wr_count`=0. After release, with `req[2]` and `req[3]` both high, owner 2 is granted first (ptr=0).
